// File: rtl/lsy201_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsy201_cmd_ctrl
// Purpose  : LSY201 JPEG camera command sequencer between host and 8N1 UART.
// Revision : 1.0 - initial release
// ============================================================================
module lsy201_cmd_ctrl #(
   parameter int unsigned FREQ_HZ    = 100000000,
   parameter int unsigned TIMEOUT_MS = 50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  cmd,
   input  logic        cmd_start,
   input  logic [15:0] rd_addr,
   input  logic [15:0] rd_len,
   output logic        cmd_busy,
   output logic        cmd_done,
   output logic        cmd_err,
   output logic [15:0] img_size,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic [7:0]  tx_data,
   output logic        tx_wr,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        rx_avail,
   input  logic        rx_error,
   output logic        rx_ack
);

   localparam logic [63:0] c_TMO_LIMIT = 64'(TIMEOUT_MS) * 64'(FREQ_HZ) / 64'd1000;
   localparam int          c_TMO_W     = (c_TMO_LIMIT < 64'd2) ? 1 : $clog2(c_TMO_LIMIT + 64'd1);
   localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(c_TMO_LIMIT - 64'd1);

   localparam logic [2:0] c_CMD_RESET = 3'd0;
   localparam logic [2:0] c_CMD_TAKE  = 3'd1;
   localparam logic [2:0] c_CMD_SIZE  = 3'd2;
   localparam logic [2:0] c_CMD_STOP  = 3'd3;
   localparam logic [2:0] c_CMD_READ  = 3'd4;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_SEND   = 4'd1,
      S_TXWAIT = 4'd2,
      S_RESP   = 4'd3,
      S_DATA   = 4'd4,
      S_TAIL   = 4'd5,
      S_DONE   = 4'd6,
      S_ERR    = 4'd7
   } state_t;

   function automatic logic [7:0] f_cmd_id(input logic [2:0] c);
      logic [7:0] b;
      case (c)
         c_CMD_RESET: b = 8'h26;
         c_CMD_SIZE:  b = 8'h34;
         c_CMD_READ:  b = 8'h32;
         default:     b = 8'h36;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] f_tx_byte(input logic [2:0] c, input logic [4:0] idx,
                                            input logic [15:0] addr, input logic [15:0] len);
      logic [7:0] b;
      case (idx)
         5'd0:        b = 8'h56;
         5'd2:        b = f_cmd_id(c);
         5'd3:        b = (c == c_CMD_RESET) ? 8'h00 : ((c == c_CMD_READ) ? 8'h0C : 8'h01);
         5'd4:        b = (c == c_CMD_STOP) ? 8'h03 : 8'h00;
         5'd5, 5'd15: b = 8'h0A;
         5'd8:        b = addr[15:8];
         5'd9:        b = addr[7:0];
         5'd12:       b = len[15:8];
         5'd13:       b = len[7:0];
         default:     b = 8'h00;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] f_rx_byte(input logic [2:0] c, input logic [4:0] idx);
      logic [7:0] b;
      case (idx)
         5'd0:    b = 8'h76;
         5'd2:    b = f_cmd_id(c);
         5'd4:    b = (c == c_CMD_SIZE) ? 8'h04 : 8'h00;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   function automatic logic [4:0] f_tx_last(input logic [2:0] c);
      logic [4:0] n;
      case (c)
         c_CMD_RESET: n = 5'd3;
         c_CMD_READ:  n = 5'd15;
         default:     n = 5'd4;
      endcase
      return n;
   endfunction

   function automatic logic [4:0] f_rx_last(input logic [2:0] c);
      logic [4:0] n;
      case (c)
         c_CMD_RESET: n = 5'd3;
         c_CMD_SIZE:  n = 5'd8;
         default:     n = 5'd4;
      endcase
      return n;
   endfunction

   state_t             r_state, w_state_nxt;
   logic [2:0]         r_cmd, w_cmd_nxt;
   logic [15:0]        r_addr, w_addr_nxt;
   logic [15:0]        r_len, w_len_nxt;
   logic [15:0]        r_cnt, w_cnt_nxt;
   logic [4:0]         r_idx, w_idx_nxt;
   logic [c_TMO_W-1:0] r_tmo, w_tmo_nxt;
   logic [7:0]         r_size_hi, w_size_hi_nxt;
   logic [15:0]        w_img_size_nxt;
   logic [7:0]         w_data_out_nxt, w_tx_data_nxt;
   logic               w_busy_nxt, w_done_nxt, w_err_nxt;
   logic               w_dvalid_nxt, w_tx_wr_nxt, w_rx_ack_nxt;
   logic               w_fail, w_finish;

   logic               w_rx_take;
   logic [7:0]         w_exp;
   logic [4:0]         w_rx_last;
   logic               w_wild;
   logic               w_tmo_exp;

   // rx_ack high means the UART has not yet retired the byte just consumed
   assign w_rx_take = rx_avail && !rx_ack;
   assign w_rx_last = (r_state == S_TAIL) ? 5'd4 : f_rx_last(r_cmd);
   assign w_exp     = (r_state == S_TAIL) ? f_rx_byte(c_CMD_READ, r_idx) : f_rx_byte(r_cmd, r_idx);
   assign w_wild    = (r_state == S_RESP) && (r_cmd == c_CMD_SIZE) && (r_idx >= 5'd7);
   assign w_tmo_exp = (r_tmo == c_TMO_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cmd      <= 3'd0;
         r_addr     <= 16'd0;
         r_len      <= 16'd0;
         r_cnt      <= 16'd0;
         r_idx      <= 5'd0;
         r_tmo      <= '0;
         r_size_hi  <= 8'd0;
         img_size   <= 16'd0;
         data_out   <= 8'd0;
         tx_data    <= 8'd0;
         cmd_busy   <= 1'b0;
         cmd_done   <= 1'b0;
         cmd_err    <= 1'b0;
         data_valid <= 1'b0;
         tx_wr      <= 1'b0;
         rx_ack     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cmd      <= w_cmd_nxt;
         r_addr     <= w_addr_nxt;
         r_len      <= w_len_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_tmo      <= w_tmo_nxt;
         r_size_hi  <= w_size_hi_nxt;
         img_size   <= w_img_size_nxt;
         data_out   <= w_data_out_nxt;
         tx_data    <= w_tx_data_nxt;
         cmd_busy   <= w_busy_nxt;
         cmd_done   <= w_done_nxt;
         cmd_err    <= w_err_nxt;
         data_valid <= w_dvalid_nxt;
         tx_wr      <= w_tx_wr_nxt;
         rx_ack     <= w_rx_ack_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cmd_nxt      = r_cmd;
      w_addr_nxt     = r_addr;
      w_len_nxt      = r_len;
      w_cnt_nxt      = r_cnt;
      w_idx_nxt      = r_idx;
      w_tmo_nxt      = r_tmo;
      w_size_hi_nxt  = r_size_hi;
      w_img_size_nxt = img_size;
      w_data_out_nxt = data_out;
      w_tx_data_nxt  = tx_data;
      w_busy_nxt     = cmd_busy;
      w_done_nxt     = 1'b0;
      w_err_nxt      = 1'b0;
      w_dvalid_nxt   = 1'b0;
      w_tx_wr_nxt    = 1'b0;
      w_rx_ack_nxt   = 1'b0;
      w_fail         = 1'b0;
      w_finish       = 1'b0;

      case (r_state)
         S_IDLE: begin
            // Anything arriving unsolicited (e.g. the power-up banner) is dropped
            if (w_rx_take) begin
               w_rx_ack_nxt = 1'b1;
            end
            if (cmd_start) begin
               if (cmd <= c_CMD_READ) begin
                  w_cmd_nxt   = cmd;
                  w_addr_nxt  = rd_addr;
                  w_len_nxt   = rd_len;
                  w_idx_nxt   = 5'd0;
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = S_SEND;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end

         S_SEND: begin
            if (!tx_busy) begin
               w_tx_data_nxt = f_tx_byte(r_cmd, r_idx, r_addr, r_len);
               w_tx_wr_nxt   = 1'b1;
               w_state_nxt   = S_TXWAIT;
            end
         end

         S_TXWAIT: begin
            // tx_busy lags the write strobe by a cycle, so skip the strobe cycle
            if (!tx_wr && !tx_busy) begin
               if (r_idx == f_tx_last(r_cmd)) begin
                  w_idx_nxt   = 5'd0;
                  w_tmo_nxt   = '0;
                  w_state_nxt = S_RESP;
               end else begin
                  w_idx_nxt   = r_idx + 5'd1;
                  w_state_nxt = S_SEND;
               end
            end
         end

         S_RESP, S_TAIL: begin
            if (w_rx_take) begin
               w_rx_ack_nxt = 1'b1;
               w_tmo_nxt    = '0;
               if (rx_error || (!w_wild && (rx_data != w_exp))) begin
                  w_fail = 1'b1;
               end else begin
                  if (w_wild && (r_idx == 5'd7)) begin
                     w_size_hi_nxt = rx_data;
                  end
                  if (r_idx == w_rx_last) begin
                     w_idx_nxt = 5'd0;
                     if ((r_state == S_RESP) && (r_cmd == c_CMD_READ)) begin
                        if (r_len != 16'd0) begin
                           w_cnt_nxt   = r_len;
                           w_state_nxt = S_DATA;
                        end else begin
                           w_state_nxt = S_TAIL;
                        end
                     end else begin
                        if (w_wild) begin
                           w_img_size_nxt = {r_size_hi, rx_data};
                        end
                        w_finish = 1'b1;
                     end
                  end else begin
                     w_idx_nxt = r_idx + 5'd1;
                  end
               end
            end else if (w_tmo_exp) begin
               w_fail = 1'b1;
            end else begin
               w_tmo_nxt = r_tmo + c_TMO_W'(1);
            end
         end

         S_DATA: begin
            if (w_rx_take) begin
               w_rx_ack_nxt = 1'b1;
               w_tmo_nxt    = '0;
               if (rx_error) begin
                  w_fail = 1'b1;
               end else begin
                  w_data_out_nxt = rx_data;
                  w_dvalid_nxt   = 1'b1;
                  w_cnt_nxt      = r_cnt - 16'd1;
                  if (r_cnt == 16'd1) begin
                     w_idx_nxt   = 5'd0;
                     w_state_nxt = S_TAIL;
                  end
               end
            end else if (w_tmo_exp) begin
               w_fail = 1'b1;
            end else begin
               w_tmo_nxt = r_tmo + c_TMO_W'(1);
            end
         end

         S_DONE:  w_state_nxt = S_IDLE;
         S_ERR:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase

      // The done/err pulse coincides with the one-cycle DONE/ERR state
      if (w_fail) begin
         w_err_nxt   = 1'b1;
         w_busy_nxt  = 1'b0;
         w_state_nxt = S_ERR;
      end else if (w_finish) begin
         w_done_nxt  = 1'b1;
         w_busy_nxt  = 1'b0;
         w_state_nxt = S_DONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsy201_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsy201_cmd_ctrl
// Purpose  : Directed self-checking bench for lsy201_cmd_ctrl with UART models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsy201_cmd_ctrl;

   localparam int unsigned c_FREQ   = 100000;
   localparam int unsigned c_TMO_MS = 1;
   localparam int          c_LIMIT  = int'(c_TMO_MS * c_FREQ / 1000);

   typedef logic [7:0] byte_q_t[$];

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  cmd;
   logic        cmd_start;
   logic [15:0] rd_addr, rd_len;
   logic        cmd_busy, cmd_done, cmd_err, data_valid, tx_wr, rx_ack;
   logic [15:0] img_size;
   logic [7:0]  data_out, tx_data;
   logic        tx_busy;
   logic [7:0]  rx_data;
   logic        rx_avail;
   logic        rx_error;

   int n_chk = 0, n_fail = 0;
   int cyc = 0, n_done = 0, n_errp = 0, n_ack = 0, err_cyc = 0, last_fall = 0;
   byte_q_t tx_log, dv_log, rx_q, exp;
   logic [2:0] busy_cnt;
   logic [1:0] rx_gap;

   always #5 clk = ~clk;

   lsy201_cmd_ctrl #(.FREQ_HZ(c_FREQ), .TIMEOUT_MS(c_TMO_MS)) dut (
      .clk(clk), .reset(reset), .cmd(cmd), .cmd_start(cmd_start),
      .rd_addr(rd_addr), .rd_len(rd_len), .cmd_busy(cmd_busy), .cmd_done(cmd_done),
      .cmd_err(cmd_err), .img_size(img_size), .data_out(data_out), .data_valid(data_valid),
      .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy), .rx_data(rx_data),
      .rx_avail(rx_avail), .rx_error(rx_error), .rx_ack(rx_ack)
   );

   // Event monitor; values sampled at the edge are the previous cycle's outputs
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cmd_done) n_done <= n_done + 1;
      if (cmd_err) begin
         n_errp  <= n_errp + 1;
         err_cyc <= cyc;
      end
      if (rx_ack) n_ack <= n_ack + 1;
      if (data_valid) dv_log.push_back(data_out);
      if (tx_wr) tx_log.push_back(tx_data);
   end

   // UART transmitter: busy for four cycles after each write
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_cnt <= 3'd0;
      end else if (tx_wr) begin
         busy_cnt <= 3'd4;
      end else if (busy_cnt != 3'd0) begin
         busy_cnt <= busy_cnt - 3'd1;
         if (busy_cnt == 3'd1) last_fall <= cyc + 1;
      end
   end
   assign tx_busy = (busy_cnt != 3'd0);

   // UART receiver: presents queued bytes, retires one per ack
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_avail <= 1'b0;
         rx_data  <= 8'd0;
         rx_gap   <= 2'd0;
         rx_q.delete();
      end else if (rx_avail) begin
         if (rx_ack) begin
            rx_avail <= 1'b0;
            rx_gap   <= 2'd2;
         end
      end else if (rx_gap != 2'd0) begin
         rx_gap <= rx_gap - 2'd1;
      end else if (rx_q.size() != 0) begin
         rx_data  <= rx_q.pop_front();
         rx_avail <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_tx(input string tag, input int base, input byte_q_t e);
      chk({tag, "_len"}, 32'(tx_log.size() - base), 32'(e.size()));
      for (int i = 0; i < e.size(); i++) begin
         if (base + i < tx_log.size())
            chk($sformatf("%s_b%0d", tag, i), {24'd0, tx_log[base + i]}, {24'd0, e[i]});
      end
   endtask

   task automatic start_cmd(input logic [2:0] c, input logic [15:0] a, input logic [15:0] l);
      @(negedge clk);
      cmd = c; rd_addr = a; rd_len = l; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
   endtask

   task automatic push_all(input byte_q_t b);
      foreach (b[i]) rx_q.push_back(b[i]);
   endtask

   task automatic run_wait(input int limit, output int got);
      int base;
      base = n_done + n_errp;
      got  = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (n_done + n_errp != base) begin
            got = 1;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {26'd0, cmd_busy, cmd_done, cmd_err, data_valid, tx_wr, rx_ack}, 32'd0);
      chk({tag, "_img"}, {16'd0, img_size}, 32'd0);
      chk({tag, "_dout"}, {24'd0, data_out}, 32'd0);
      chk({tag, "_txd"}, {24'd0, tx_data}, 32'd0);
   endtask

   initial begin
      int got, b_tx, b_done, b_err, b_ack, b_dv;
      reset = 1'b1; cmd = 3'd0; cmd_start = 1'b0; rd_addr = 16'd0; rd_len = 16'd0; rx_error = 1'b0;
      idle(3);
      chk_zero("reset");
      reset = 1'b0;
      idle(3);

      // SIZE
      b_tx = tx_log.size(); b_done = n_done; b_err = n_errp;
      start_cmd(3'd2, 16'd0, 16'd0);
      chk("size_busy", {31'd0, cmd_busy}, 32'd1);
      exp = '{8'h76, 8'h00, 8'h34, 8'h00, 8'h04, 8'h00, 8'h00, 8'h12, 8'h34};
      push_all(exp);
      run_wait(2000, got);
      chk("size_end", got, 1);
      idle(10);
      exp = '{8'h56, 8'h00, 8'h34, 8'h01, 8'h00};
      chk_tx("size_tx", b_tx, exp);
      chk("size_img", {16'd0, img_size}, 32'h1234);
      chk("size_done", n_done - b_done, 1);
      chk("size_err", n_errp - b_err, 0);
      chk("size_idle", {31'd0, cmd_busy}, 32'd0);

      // READ, three payload bytes
      b_tx = tx_log.size(); b_done = n_done; b_err = n_errp; b_dv = dv_log.size();
      start_cmd(3'd4, 16'h0020, 16'd3);
      exp = '{8'h76, 8'h00, 8'h32, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC,
              8'h76, 8'h00, 8'h32, 8'h00, 8'h00};
      push_all(exp);
      run_wait(3000, got);
      chk("read_end", got, 1);
      idle(10);
      exp = '{8'h56, 8'h00, 8'h32, 8'h0C, 8'h00, 8'h0A, 8'h00, 8'h00,
              8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h0A};
      chk_tx("read_tx", b_tx, exp);
      chk("read_dv_cnt", dv_log.size() - b_dv, 3);
      if (dv_log.size() >= b_dv + 3) begin
         chk("read_d0", {24'd0, dv_log[b_dv]},     32'hAA);
         chk("read_d1", {24'd0, dv_log[b_dv + 1]}, 32'hBB);
         chk("read_d2", {24'd0, dv_log[b_dv + 2]}, 32'hCC);
      end
      chk("read_done", n_done - b_done, 1);
      chk("read_err", n_errp - b_err, 0);
      chk("read_img_kept", {16'd0, img_size}, 32'h1234);

      // TAKE with a wrong 4th reply byte and a second start ignored mid-command
      b_tx = tx_log.size(); b_done = n_done; b_err = n_errp; b_ack = n_ack;
      start_cmd(3'd1, 16'd0, 16'd0);
      idle(2);
      start_cmd(3'd4, 16'hFFFF, 16'd5);
      exp = '{8'h76, 8'h00, 8'h36, 8'h01, 8'h00};
      push_all(exp);
      run_wait(2000, got);
      chk("take_end", got, 1);
      chk("take_acks", n_ack - b_ack, 4);
      idle(20);
      exp = '{8'h56, 8'h00, 8'h36, 8'h01, 8'h00};
      chk_tx("take_tx", b_tx, exp);
      chk("take_err", n_errp - b_err, 1);
      chk("take_done", n_done - b_done, 0);
      chk("take_idle", {31'd0, cmd_busy}, 32'd0);

      // STOP with a silent camera
      b_tx = tx_log.size(); b_done = n_done; b_err = n_errp;
      start_cmd(3'd3, 16'd0, 16'd0);
      run_wait(2000, got);
      chk("stop_end", got, 1);
      chk("stop_tmo_win", {31'd0, ((err_cyc - last_fall) >= c_LIMIT - 2) &&
                                  ((err_cyc - last_fall) <= c_LIMIT + 2)}, 32'd1);
      idle(10);
      exp = '{8'h56, 8'h00, 8'h36, 8'h01, 8'h03};
      chk_tx("stop_tx", b_tx, exp);
      chk("stop_err", n_errp - b_err, 1);
      chk("stop_done", n_done - b_done, 0);

      // Illegal command
      b_tx = tx_log.size();
      @(negedge clk);
      cmd = 3'd6; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk("ill_err", {31'd0, cmd_err}, 32'd1);
      chk("ill_busy", {31'd0, cmd_busy}, 32'd0);
      idle(10);
      chk("ill_tx", tx_log.size() - b_tx, 0);

      // Stray bytes in IDLE
      b_ack = n_ack; b_dv = dv_log.size();
      exp = '{8'h11, 8'h22, 8'h33};
      push_all(exp);
      idle(30);
      chk("stray_acks", n_ack - b_ack, 3);
      chk("stray_dv", dv_log.size() - b_dv, 0);

      // Reset mid-READ after one payload byte
      b_done = n_done; b_err = n_errp; b_dv = dv_log.size();
      start_cmd(3'd4, 16'h0100, 16'd4);
      exp = '{8'h76, 8'h00, 8'h32, 8'h00, 8'h00, 8'h5A};
      push_all(exp);
      got = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (dv_log.size() > b_dv) begin
            got = 1;
            break;
         end
      end
      chk("rstmid_payload", got, 1);
      idle(2);
      reset = 1'b1;
      #1;
      chk_zero("rstmid");
      idle(2);
      reset = 1'b0;
      idle(20);
      chk("rstmid_done", n_done - b_done, 0);
      chk("rstmid_err", n_errp - b_err, 0);

      // RESET command recovers the camera
      b_tx = tx_log.size(); b_done = n_done;
      start_cmd(3'd0, 16'd0, 16'd0);
      exp = '{8'h76, 8'h00, 8'h26, 8'h00};
      push_all(exp);
      run_wait(2000, got);
      chk("rcmd_end", got, 1);
      idle(10);
      exp = '{8'h56, 8'h00, 8'h26, 8'h00};
      chk_tx("rcmd_tx", b_tx, exp);
      chk("rcmd_done", n_done - b_done, 1);

      $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
